sequenciador_ciclos: RTL and testbench
======================================

# sequenciador_ciclos

Multicycle sequencer for the RV32 subset datapath (lw, sw, sub, xor, addi, srl, beq). It drives the 4-bit `estado` bus consumed by the PC adder, instruction fetch, decode, control, register file, ALU and data memory. It decodes the instruction class in ID to select the state path, and waits on a data-memory ready handshake with timeout. It halts on a zero instruction, an unsupported opcode or a memory timeout, and keeps instruction and cycle counters.

## Interface
- `MEM_TIMEOUT`, 15: maximum cycles spent in MEM waiting for `mem_ready` (1..255).
- `INSTR_CNT_W`, 16: width of the retired-instruction counter.
- `clk  in  1`: single clock; all state updates on rising edge.
- `rst  in  1`: asynchronous, active-low reset.
- `start  in  1`: begin execution; sampled only in IDLE.
- `instrucao  in  32`: fetched instruction; valid during ID.
- `mem_ready  in  1`: data memory has completed the current lw/sw access.
- `estado  out  4`: current state code.
- `busy  out  1`: high in every state except IDLE and FIM.
- `halted  out  1`: high in FIM.
- `illegal  out  1`: sticky; unsupported opcode seen in ID.
- `fault  out  1`: sticky; MEM timeout occurred.
- `instr_count  out  INSTR_CNT_W`: retired instructions, saturating.
- `cycle_count  out  32`: cycles spent busy, wrapping.

## Operation
- State encodings:
  - IF 0000, ID 0001, EX 0010, AUX1 0101, AUX2 1111, MEM 0011, WB 0100.
  - AUX3 0110, AUX4 0111, SUMPC 1000, FIM 1001, IDLE 1010.
- Reset values:
  - `estado` = IDLE; `busy`, `halted`, `illegal`, `fault` = 0.
  - Counters = 0; internal latched class = none; wait counter = 0.
- IDLE: `start`=1 moves to IF; otherwise stays in IDLE.
- IF moves to ID.
- ID decodes the instruction and latches the class from `instrucao[6:0]`:
  - 0000011 = LOAD, 0100011 = STORE, 0110011 = ALU_R, 0010011 = ALU_I, 1100011 = BRANCH.
  - `instrucao`==0 moves to FIM; `illegal` stays 0.
  - Any other nonzero opcode moves to FIM and sets `illegal`=1.
  - A supported opcode moves to EX.
  - All later decisions use the latched class; changes on `instrucao` after ID are ignored.
- Base path, fixed for every class: EX, AUX1, AUX2, MEM, WB, AUX3, AUX4, SUMPC, IF.
- MEM behaviour:
  - LOAD/STORE: remain in MEM until `mem_ready`=1, then go to WB on the next edge.
  - The wait counter clears on MEM entry and increments each MEM cycle with `mem_ready`=0.
  - If the counter reaches `MEM_TIMEOUT` with `mem_ready`=0, go to FIM and set `fault`=1.
  - If `mem_ready`=1 on the same cycle the counter reaches the limit, ready wins and the next state is WB.
  - Other classes: MEM lasts exactly 1 cycle; `mem_ready` is ignored.
- SUMPC: `instr_count` increments, saturating at all-ones.
- `cycle_count` increments on every edge where `busy`=1.
- FIM is terminal. `start` is ignored there; only `rst` leaves FIM.
- Reset mid-instruction aborts immediately to IDLE and clears everything.

## Timing
- `estado` is registered, changes only on rising `clk` or on asynchronous `rst` assertion.
- All outputs are registered or decoded directly from the state register; no input-to-output combinational path.
- `start` high in IDLE: IF is visible the following cycle.
- Base-path latency per instruction, IF through SUMPC: 10 cycles with `mem_ready` already high; LOAD/STORE add 1 cycle per MEM cycle with `mem_ready` low.
- A timeout reaches FIM `MEM_TIMEOUT`+1 cycles after MEM entry.
- `illegal` and `fault` rise in the same cycle FIM is entered.

## Configuration
- `SEQ_FASTPATH_EN` defined: non-memory classes skip states.
  - ALU_R/ALU_I path: EX, AUX1, AUX2, WB, SUMPC (7 cycles per instruction).
  - BRANCH path: EX, AUX1, AUX2, SUMPC (6 cycles).
  - LOAD/STORE are unchanged.
- `SEQ_FASTPATH_EN` undefined: every class uses the base path.

## Test plan
- Reset, hold `start`=0 for 5 cycles, then `start`=1 -> `estado`=1010 throughout, then IF (0000) next cycle; `cycle_count` starts incrementing.
- One addi followed by `instrucao`=0, base build:
  - Required sequence: 0000,0001,0010,0101,1111,0011,0100,0110,0111,1000,0000,0001,1001.
  - At the end `instr_count`=1, `halted`=1.
- lw with `mem_ready` held low 3 MEM cycles, then high -> MEM occupies 4 cycles, then WB; `fault`=0.
- sw with `mem_ready` never high, `MEM_TIMEOUT`=15 -> FIM after 16 MEM cycles, `fault`=1.
- Opcode 1101111 in ID -> FIM next cycle, `illegal`=1; `start` pulses are then ignored.
- With `SEQ_FASTPATH_EN`:
  - Sequence xor, beq, zero: paths of 7 and 6 cycles respectively, then FIM.
  - `instr_count`=2.
  - `rst` pulsed low mid-sequence -> IDLE immediately and all counters 0.

Source files
------------

// File: rtl/sequenciador_ciclos.sv
// Multicycle sequencer for the RV32 subset datapath; optional SEQ_FASTPATH_EN shortens non-memory paths.
// Latency: 10 cycles per instruction IF..SUMPC (+1 per MEM cycle waiting on mem_ready); estado registered.
// Backpressure: stalls in MEM until mem_ready, halting with fault after MEM_TIMEOUT idle cycles.
module sequenciador_ciclos #(
  parameter int MEM_TIMEOUT = 15,
  parameter int INSTR_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [31:0]            instrucao,
  input  logic                   mem_ready,
  output logic [3:0]             estado,
  output logic                   busy,
  output logic                   halted,
  output logic                   illegal,
  output logic                   fault,
  output logic [INSTR_CNT_W-1:0] instr_count,
  output logic [31:0]            cycle_count
);

  typedef enum logic [3:0] {
    S_IF    = 4'b0000,
    S_ID    = 4'b0001,
    S_EX    = 4'b0010,
    S_MEM   = 4'b0011,
    S_WB    = 4'b0100,
    S_AUX1  = 4'b0101,
    S_AUX3  = 4'b0110,
    S_AUX4  = 4'b0111,
    S_SUMPC = 4'b1000,
    S_FIM   = 4'b1001,
    S_IDLE  = 4'b1010,
    S_AUX2  = 4'b1111
  } state_t;

  typedef enum logic [2:0] {
    C_NONE, C_LOAD, C_STORE, C_ALU_R, C_ALU_I, C_BRANCH
  } cls_t;

  localparam logic [7:0]             TMO      = 8'(MEM_TIMEOUT);
  localparam logic [INSTR_CNT_W-1:0] ICNT_ONE = {{(INSTR_CNT_W-1){1'b0}}, 1'b1};

  state_t     state, nxt;
  cls_t       cls, cls_dec;
  logic [7:0] wait_cnt;
  logic       set_ill, set_flt;
  logic       is_mem, is_alu;

  always_comb begin
    cls_dec = C_NONE;
    case (instrucao[6:0])
      7'b0000011: cls_dec = C_LOAD;
      7'b0100011: cls_dec = C_STORE;
      7'b0110011: cls_dec = C_ALU_R;
      7'b0010011: cls_dec = C_ALU_I;
      7'b1100011: cls_dec = C_BRANCH;
      default:    cls_dec = C_NONE;
    endcase
  end

  // Past ID every decision uses the latched class, never the live bus.
  assign is_mem = (cls == C_LOAD) || (cls == C_STORE);
  assign is_alu = (cls == C_ALU_R) || (cls == C_ALU_I);

  always_comb begin
    nxt     = state;
    set_ill = 1'b0;
    set_flt = 1'b0;
    case (state)
      S_IDLE:  nxt = start ? S_IF : S_IDLE;
      S_IF:    nxt = S_ID;
      S_ID: begin
        if (instrucao == 32'd0) begin
          nxt = S_FIM;
        end else if (cls_dec == C_NONE) begin
          nxt     = S_FIM;
          set_ill = 1'b1;
        end else begin
          nxt = S_EX;
        end
      end
      S_EX:    nxt = S_AUX1;
      S_AUX1:  nxt = S_AUX2;
      S_AUX2: begin
`ifdef SEQ_FASTPATH_EN
        if (cls == C_BRANCH)  nxt = S_SUMPC;
        else if (is_alu)      nxt = S_WB;
        else                  nxt = S_MEM;
`else
        nxt = S_MEM;
`endif
      end
      S_MEM: begin
        if (!is_mem || mem_ready) begin
          nxt = S_WB;
        end else if (wait_cnt == TMO) begin
          nxt     = S_FIM;
          set_flt = 1'b1;
        end
      end
      S_WB: begin
`ifdef SEQ_FASTPATH_EN
        nxt = is_alu ? S_SUMPC : S_AUX3;
`else
        nxt = S_AUX3;
`endif
      end
      S_AUX3:  nxt = S_AUX4;
      S_AUX4:  nxt = S_SUMPC;
      S_SUMPC: nxt = S_IF;
      S_FIM:   nxt = S_FIM;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cls         <= C_NONE;
      wait_cnt    <= 8'd0;
      illegal     <= 1'b0;
      fault       <= 1'b0;
      instr_count <= '0;
      cycle_count <= 32'd0;
    end else begin
      state <= nxt;
      if (state == S_ID) cls <= cls_dec;
      // Cleared outside MEM so every MEM entry starts counting from zero.
      if (state != S_MEM)  wait_cnt <= 8'd0;
      else if (!mem_ready) wait_cnt <= wait_cnt + 8'd1;
      if (set_ill) illegal <= 1'b1;
      if (set_flt) fault   <= 1'b1;
      if (state == S_SUMPC && instr_count != '1) instr_count <= instr_count + ICNT_ONE;
      if (busy) cycle_count <= cycle_count + 32'd1;
    end
  end

  assign estado = state;
  assign busy   = (state != S_IDLE) && (state != S_FIM);
  assign halted = (state == S_FIM);

endmodule

// File: tb/tb_sequenciador_ciclos.sv
// Scoreboard bench for sequenciador_ciclos: per-cycle expected state/flags/counters queued with stimulus.
module tb_sequenciador_ciclos;

  localparam int TMO = 15;
  localparam logic [3:0] IF_ = 4'b0000, ID_ = 4'b0001, EX_ = 4'b0010, AUX1 = 4'b0101,
                         AUX2 = 4'b1111, MEM = 4'b0011, WB_ = 4'b0100, AUX3 = 4'b0110,
                         AUX4 = 4'b0111, SUMPC = 4'b1000, FIM = 4'b1001, IDLE = 4'b1010;

  localparam logic [31:0] I_ADDI = 32'h0010_0093, I_LW  = 32'h0000_2083,
                          I_SW   = 32'h0010_2023, I_XOR = 32'h0020_c1b3,
                          I_BEQ  = 32'h0000_0463, I_JAL = 32'h0000_006f;

  logic        clk, rst, start, mem_ready;
  logic [31:0] instrucao;
  logic [3:0]  estado;
  logic        busy, halted, illegal, fault;
  logic [15:0] instr_count;
  logic [31:0] cycle_count;

  sequenciador_ciclos #(.MEM_TIMEOUT(TMO), .INSTR_CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .instrucao(instrucao), .mem_ready(mem_ready),
    .estado(estado), .busy(busy), .halted(halted), .illegal(illegal), .fault(fault),
    .instr_count(instr_count), .cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  st;
    logic        start;
    logic [31:0] instr;
    logic        rdy;
    logic        flt;
    logic        ill;
    logic [15:0] ins;
    logic [31:0] cyc;
  } ent_t;

  ent_t sb[$];
  int   n_pass = 0, n_total = 0;
  logic m_flt, m_ill;
  logic [15:0] m_ins;
  logic [31:0] m_cyc;

  task automatic model_clear();
    m_flt = 0; m_ill = 0; m_ins = 0; m_cyc = 0;
    sb.delete();
  endtask

  task automatic push(input logic [3:0] st, input logic st_in, input logic [31:0] ins, input logic rdy);
    ent_t e;
    e.st = st; e.start = st_in; e.instr = ins; e.rdy = rdy;
    e.flt = m_flt; e.ill = m_ill; e.ins = m_ins; e.cyc = m_cyc;
    sb.push_back(e);
    if (st != IDLE && st != FIM) m_cyc = m_cyc + 1;
    if (st == SUMPC && m_ins != 16'hFFFF) m_ins = m_ins + 1;
  endtask

  // Expected path for one instruction; waits = MEM cycles with mem_ready low.
  task automatic push_instr(input logic [31:0] ins, input int waits);
    logic [6:0] op;
    op = ins[6:0];
    push(IF_, 0, 0, 0);
    push(ID_, 0, ins, 0);
    if (ins == 32'd0) begin push(FIM, 0, 0, 0); return; end
    if (op != 7'b0000011 && op != 7'b0100011 && op != 7'b0110011 &&
        op != 7'b0010011 && op != 7'b1100011) begin
      m_ill = 1; push(FIM, 0, 0, 0); return;
    end
    push(EX_, 0, 0, 0); push(AUX1, 0, 0, 0); push(AUX2, 0, 0, 0);
    if (op == 7'b0000011 || op == 7'b0100011) begin
      for (int k = 0; k < 300; k++) begin
        if (k >= waits) begin push(MEM, 0, 0, 1); break; end
        push(MEM, 0, 0, 0);
        if (k == TMO) begin m_flt = 1; push(FIM, 0, 0, 0); return; end
      end
      push(WB_, 0, 0, 0); push(AUX3, 0, 0, 0); push(AUX4, 0, 0, 0); push(SUMPC, 0, 0, 0);
    end else begin
`ifdef SEQ_FASTPATH_EN
      if (op != 7'b1100011) push(WB_, 0, 0, 0);
      push(SUMPC, 0, 0, 0);
`else
      push(MEM, 0, 0, 0); push(WB_, 0, 0, 0); push(AUX3, 0, 0, 0);
      push(AUX4, 0, 0, 0); push(SUMPC, 0, 0, 0);
`endif
    end
  endtask

  task automatic drain(input string tag);
    ent_t e;
    int cyc = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      n_total += 4;
      if (estado !== e.st)
        $display("FAIL %s estado cyc%0d: got %b want %b", tag, cyc, estado, e.st);
      else n_pass++;
      if ({busy, halted} !== {(e.st != IDLE && e.st != FIM), (e.st == FIM)})
        $display("FAIL %s busy/halted cyc%0d: got %b%b st %b", tag, cyc, busy, halted, e.st);
      else n_pass++;
      if ({illegal, fault} !== {e.ill, e.flt})
        $display("FAIL %s ill/flt cyc%0d: got %b%b want %b%b", tag, cyc, illegal, fault, e.ill, e.flt);
      else n_pass++;
      if (instr_count !== e.ins || cycle_count !== e.cyc)
        $display("FAIL %s counters cyc%0d: got %0d/%0d want %0d/%0d", tag, cyc,
                 instr_count, cycle_count, e.ins, e.cyc);
      else n_pass++;
      start = e.start; instrucao = e.instr; mem_ready = e.rdy;
      cyc++;
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 0; start = 0; instrucao = 0; mem_ready = 0;
    @(negedge clk);
    rst = 1;
    model_clear();
  endtask

  task automatic test_reset();
    rst = 0; start = 0; instrucao = 0; mem_ready = 0;
    repeat (2) @(negedge clk);
    n_total++;
    if ({estado, busy, halted, illegal, fault} !== {IDLE, 4'b0000} || instr_count !== 0 || cycle_count !== 0)
      $display("FAIL reset: estado %b flags %b%b%b%b cnt %0d/%0d", estado, busy, halted,
               illegal, fault, instr_count, cycle_count);
    else n_pass++;
    rst = 1;
    model_clear();
  endtask

  task automatic test_start_addi();
    for (int i = 0; i < 5; i++) push(IDLE, 0, 0, 0);
    push(IDLE, 1, 0, 0);
    push_instr(I_ADDI, 0);
    push_instr(32'd0, 0);
    push(FIM, 1, 0, 0);
    drain("addi");
    n_total++;
    if (instr_count !== 16'd1 || halted !== 1'b1 || illegal !== 1'b0)
      $display("FAIL addi_end: ic %0d halted %b ill %b want 1 1 0", instr_count, halted, illegal);
    else n_pass++;
  endtask

  task automatic test_lw_wait();
    reset_dut();
    push(IDLE, 1, 0, 0);
    push_instr(I_LW, 3);
    push_instr(32'd0, 0);
    drain("lw_wait");
    n_total++;
    if (fault !== 1'b0 || instr_count !== 16'd1)
      $display("FAIL lw_end: fault %b ic %0d want 0 1", fault, instr_count);
    else n_pass++;
  endtask

  task automatic test_ready_at_limit();
    reset_dut();
    push(IDLE, 1, 0, 0);
    push_instr(I_LW, TMO);
    push_instr(32'd0, 0);
    drain("rdy_limit");
  endtask

  task automatic test_sw_timeout();
    reset_dut();
    push(IDLE, 1, 0, 0);
    push_instr(I_SW, 1000);
    push(FIM, 1, 0, 0);
    push(FIM, 0, 0, 0);
    drain("sw_tmo");
    n_total++;
    if (fault !== 1'b1 || halted !== 1'b1 || instr_count !== 16'd0)
      $display("FAIL sw_end: fault %b halted %b ic %0d want 1 1 0", fault, halted, instr_count);
    else n_pass++;
  endtask

  task automatic test_illegal();
    reset_dut();
    push(IDLE, 1, 0, 0);
    push_instr(I_JAL, 0);
    for (int i = 0; i < 4; i++) push(FIM, i[0], 0, 0);
    push(FIM, 0, 0, 0);
    drain("illegal");
  endtask

  task automatic test_back_to_back();
    reset_dut();
    push(IDLE, 1, 0, 0);
    push_instr(I_XOR, 0);
    push_instr(I_BEQ, 0);
    push_instr(32'd0, 0);
    drain("b2b");
    n_total++;
    if (instr_count !== 16'd2 || halted !== 1'b1)
      $display("FAIL b2b_end: ic %0d halted %b want 2 1", instr_count, halted);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    reset_dut();
    push(IDLE, 1, 0, 0);
    push_instr(I_ADDI, 0);
    push(IF_, 0, 0, 0);
    push(ID_, 0, I_XOR, 0);
    push(EX_, 0, 0, 0);
    drain("mid");
    #2 rst = 0;
    #1;
    n_total++;
    if (estado !== IDLE || busy !== 1'b0 || instr_count !== 0 || cycle_count !== 0)
      $display("FAIL reset_mid: estado %b busy %b cnt %0d/%0d want 1010 0 0/0",
               estado, busy, instr_count, cycle_count);
    else n_pass++;
    @(negedge clk);
    rst = 1;
    model_clear();
    push(IDLE, 0, 0, 0);
    push(IDLE, 1, 0, 0);
    push(IF_, 0, 0, 0);
    drain("post_mid");
  endtask

  initial begin
    test_reset();
    test_start_addi();
    test_lw_wait();
    test_ready_at_limit();
    test_sw_timeout();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
